// File: rtl/sram_arbiter.sv
// Two-port arbiter for the shared external 32-bit SRAM: round-robin on ties,
// fixed-length wait-state access, per-port ready in the pipeline freeze convention.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_BASE   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic [31:0] rdata0,
    output logic        ready0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata1,
    output logic        ready1,
    output logic [1:0]  grant,
    inout  wire  [31:0] sram_dq,
    output logic        sram_we_n,
    output logic [16:0] sram_address
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        win;
    logic        drive_dq;
    logic [31:0] off0, off1;
    logic        unused_addr_bits;

    // Out-of-range addresses wrap: only offset bits [18:2] select the word.
    assign off0 = addr0 - 32'(ADDR_BASE);
    assign off1 = addr1 - 32'(ADDR_BASE);
    assign unused_addr_bits = ^{off0[31:19], off0[1:0], off1[31:19], off1[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        win      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    // On a tie the port that did not own the last access wins.
                    win     = (req0 & req1) ? ~last_q : req1;
                    owner_d = win;
                    we_d    = win ? we1 : we0;
                    addr_d  = win ? off1[18:2] : off0[18:2];
                    wdata_d = win ? wdata1 : wdata0;
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q) rdata1_d = sram_dq;
                        else         rdata0_d = sram_dq;
                    end
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= 17'd0;
            wdata_q  <= 32'd0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // The done pulse is the DONE state itself, so it comes straight from a flop.
    assign ready0       = ~req0 | (state_q == DONE && !owner_q);
    assign ready1       = ~req1 | (state_q == DONE &&  owner_q);
    assign grant        = (state_q == ACCESS) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign drive_dq     = (state_q == ACCESS) && we_q;
    assign sram_we_n    = ~drive_dq;
    assign sram_dq      = drive_dq ? wdata_q : 32'bz;
    assign sram_address = addr_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model on the pins, transaction-level reference
// model of the arbitration/timeline, directed cases then random traffic.
module tb_sram_arbiter;
    localparam int W    = 5;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'd0, addr1 = 32'd0, wdata1 = 32'd0;
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1;
    logic [1:0]  grant;
    wire  [31:0] sram_dq;
    logic        sram_we_n;
    logic [16:0] sram_address;

    int total = 0;
    int bad   = 0;

    sram_arbiter #(.WAIT_CYCLES(W), .ADDR_BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ready0(ready0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ready1(ready1),
        .grant(grant), .sram_dq(sram_dq), .sram_we_n(sram_we_n), .sram_address(sram_address)
    );

    always #5 clk = ~clk;

    // SRAM device: drives the bus only while a read access is on the pins.
    logic [31:0] sram_mem [0:131071];
    logic        sram_oe;
    assign sram_oe = sram_we_n && (grant != 2'b00);
    assign sram_dq = sram_oe ? sram_mem[sram_address] : 32'bz;
    always @(posedge clk) if (!sram_we_n) sram_mem[sram_address] <= sram_dq;

    // Reference model: an access is a timeline position m_pos
    // (0 idle, 1..W on the pins, W+1 completing).
    logic [31:0] ref_mem [0:131071];
    int          m_pos, m_own, m_last;
    bit          m_we;
    logic [16:0] m_word;
    logic [31:0] m_wd;
    logic [31:0] m_rd [2];

    logic        obs_r0, obs_r1, obs_wen;
    logic [1:0]  obs_g;
    logic [16:0] obs_addr;
    logic [31:0] obs_rd0, obs_rd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [16:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[18:2];
    endfunction

    task automatic model_reset();
        m_pos = 0; m_last = 1; m_rd[0] = 32'd0; m_rd[1] = 32'd0;
    endtask

    task automatic model_edge();
        if (m_pos == 0) begin
            if (req0 || req1) begin
                m_own  = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
                m_we   = (m_own == 1) ? we1 : we0;
                m_word = word_of((m_own == 1) ? addr1 : addr0);
                m_wd   = (m_own == 1) ? wdata1 : wdata0;
                m_pos  = 1;
            end
        end else if (m_pos <= W) begin
            if (m_pos == W) begin
                if (m_we) ref_mem[m_word] = m_wd;
                else      m_rd[m_own] = ref_mem[m_word];
            end
            m_pos++;
        end else begin
            m_last = m_own;
            m_pos  = 0;
        end
    endtask

    // Called just after a falling edge with inputs already applied: checks this
    // cycle's outputs, then advances the model across the next rising edge.
    task automatic step();
        bit on_pins, done0, done1;
        if (!rst) model_reset();
        #1;
        on_pins = (m_pos >= 1 && m_pos <= W);
        done0   = (m_pos == W + 1) && (m_own == 0);
        done1   = (m_pos == W + 1) && (m_own == 1);
        obs_r0 = ready0; obs_r1 = ready1; obs_g = grant; obs_wen = sram_we_n;
        obs_addr = sram_address; obs_rd0 = rdata0; obs_rd1 = rdata1;
        chk("ready0", ready0, !req0 || done0);
        chk("ready1", ready1, !req1 || done1);
        chk("grant", grant, on_pins ? ((m_own == 1) ? 2'b10 : 2'b01) : 2'b00);
        chk("we_n", sram_we_n, !(on_pins && m_we));
        chk("rdata0", rdata0, m_rd[0]);
        chk("rdata1", rdata1, m_rd[1]);
        if (on_pins) chk("sram_address", sram_address, m_word);
        if (!rst) chk("reset_address", sram_address, 17'd0);
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
    endtask

    initial begin
        int c, prev_own, repeats, grants, cyc;
        logic [1:0] prev_g;
        for (int i = 0; i < 131072; i++) begin
            sram_mem[i] = 32'd0;
            ref_mem[i]  = 32'd0;
        end
        model_reset();
        @(negedge clk);

        // Reset held, then idle.
        step(); step();
        chk("rst_grant", obs_g, 2'b00);
        chk("rst_rdata0", obs_rd0, 32'd0);
        rst = 1'b1;
        step();
        chk("idle_ready0", obs_r0, 1'b1);
        chk("idle_ready1", obs_r1, 1'b1);
        chk("idle_we_n", obs_wen, 1'b1);

        // Port 0 write of 0xDEADBEEF to byte 1028 (word 1).
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd1028; wdata0 = 32'hDEADBEEF;
        for (int k = 0; k <= W + 1; k++) begin
            step();
            if (k >= 1 && k <= W) begin
                chk("wr_addr", obs_addr, 17'd1);
                chk("wr_we_n", obs_wen, 1'b0);
            end
            chk("wr_ready0", obs_r0, (k == W + 1) ? 1'b1 : 1'b0);
        end
        we0 = 1'b0; addr0 = 32'd1028; wdata0 = 32'd0;
        c = 0;
        do begin step(); c++; end while (!obs_r0 && c < 20);
        chk("rd_latency", c, W + 2);
        chk("rd_rdata0", obs_rd0, 32'hDEADBEEF);
        req0 = 1'b0;

        // Simultaneous requests right after reset: port 0 first.
        rst = 1'b0; step(); rst = 1'b1; step();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'd1028; addr1 = BASE + 32'd8;
        cyc = -1; prev_g = 2'b00; grants = 0;
        for (int k = 0; k < 30 && cyc < 0; k++) begin
            step();
            if (obs_g != 2'b00 && prev_g == 2'b00) begin
                chk("tie_order", obs_g, (grants == 0) ? 2'b01 : 2'b10);
                grants++;
            end
            prev_g = obs_g;
            if (obs_r0) req0 = 1'b0;
            if (obs_r1) cyc = k;
        end
        chk("tie_ready1_cycle", cyc, 2 * (W + 2) - 1);
        req1 = 1'b0;
        step();

        // Continuous requests from both ports alternate.
        req0 = 1'b1; req1 = 1'b1;
        prev_own = -1; repeats = 0; grants = 0; prev_g = 2'b00;
        for (int k = 0; k < 60; k++) begin
            step();
            if (obs_g != 2'b00 && prev_g == 2'b00) begin
                if ((obs_g == 2'b10 ? 1 : 0) == prev_own) repeats++;
                prev_own = (obs_g == 2'b10) ? 1 : 0;
                grants++;
            end
            prev_g = obs_g;
        end
        chk("alt_repeats", repeats, 0);
        chk("alt_enough", grants >= 6, 1'b1);
        req0 = 1'b0; req1 = 1'b0;
        for (int k = 0; k < 2 * (W + 2); k++) step();

        // Reset in cycle 3 of a port 1 write.
        req1 = 1'b1; we1 = 1'b1; addr1 = BASE + 32'd8; wdata1 = 32'h12345678;
        step(); step(); step();
        rst = 1'b0;
        step();
        chk("abort_ready1", obs_r1, 1'b0);
        chk("abort_grant", obs_g, 2'b00);
        chk("abort_we_n", obs_wen, 1'b1);
        ref_mem[2] = 32'h12345678;
        rst = 1'b1;
        c = 0;
        do begin step(); c++; end while (!obs_r1 && c < 20);
        chk("fresh_latency", c, W + 2);
        req1 = 1'b0; we1 = 1'b0;
        step();

        // Port 0 read; address changes and req drops in cycle 2.
        req0 = 1'b1; we0 = 1'b0; addr0 = BASE + 32'd8;
        step(); step();
        req0 = 1'b0; addr0 = BASE + 32'd40;
        for (int k = 2; k <= W + 1; k++) begin
            step();
            chk("drop_ready0", obs_r0, 1'b1);
            if (k <= W) chk("drop_addr", obs_addr, 17'd2);
        end
        chk("drop_rdata0", obs_rd0, 32'h12345678);
        step();

        // Random traffic: requesters mostly hold req until served.
        for (int k = 0; k < 600; k++) begin
            if (!req0 || obs_r0 || $urandom_range(0, 19) == 0) begin
                req0 = $urandom_range(0, 1);
                we0  = $urandom_range(0, 1);
                addr0 = ($urandom_range(0, 7) == 0) ? $urandom :
                        BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
                wdata0 = $urandom;
            end
            if (!req1 || obs_r1 || $urandom_range(0, 19) == 0) begin
                req1 = $urandom_range(0, 1);
                we1  = $urandom_range(0, 1);
                addr1 = ($urandom_range(0, 7) == 0) ? $urandom :
                        BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
                wdata1 = $urandom;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
